// File: rtl/led_breathe_multi.sv
// Multi-channel LED breathing controller.
// A shared step prescaler paces per-channel intensity sequencers
// (triangle, sawtooth or hold). Each channel drives a first-order
// accumulator PWM whose carry is the LED output. Channels start at
// evenly spaced intensity offsets so their brightness is staggered.
module led_breathe_multi #(
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  output logic [CHANNELS-1:0]          led,
  output logic [CHANNELS*PWM_BITS-1:0] level,
  output logic                         step
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_TRI  = 2'b01,
    MODE_SAW  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  mode_t          cur_mode;
  logic           active;
  logic           upd;
  logic [PW-1:0]  presc;

  assign cur_mode = mode_t'(mode);
  assign active   = (cur_mode != MODE_OFF);
  // The update edge is the prescaler wrap; it needs en so a frozen
  // prescaler never produces an update or a step pulse.
  assign upd      = en && active && (presc == LAST);

  // Step prescaler: cleared while OFF, frozen while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!active) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

  // Step pulse: high for the cycle following each update edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= 1'b0;
    end else begin
      step <= upd;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam longint OFS_FULL = (longint'(k) << PWM_BITS) / longint'(CHANNELS);
    localparam logic [PWM_BITS-1:0] OFS = OFS_FULL[PWM_BITS-1:0];

    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] acc;
    logic [PWM_BITS:0]   sum;
    logic                down;
    logic                led_bit;

    assign sum = {1'b0, acc} + {1'b0, lvl};
    assign led[k] = led_bit;
    assign level[k*PWM_BITS +: PWM_BITS] = active ? lvl : '0;

    // PWM accumulator; its carry is the registered LED bit. It always
    // sums the pre-update level, giving one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc     <= '0;
        led_bit <= 1'b0;
      end else if (!active) begin
        acc     <= '0;
        led_bit <= 1'b0;
      end else begin
        acc     <= sum[PWM_BITS-1:0];
        led_bit <= sum[PWM_BITS];
      end
    end

    // Intensity sequencer. OFF keeps reloading the stagger offset so
    // leaving OFF restarts the channel cleanly. A triangle caught at an
    // end with the wrong direction (after SAW or a MAX offset) bounces
    // back instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl  <= OFS;
        down <= 1'b0;
      end else if (!active) begin
        lvl  <= OFS;
        down <= 1'b0;
      end else if (upd) begin
        case (cur_mode)
          MODE_TRI: begin
            if (!down) begin
              if (lvl == MAX) begin
                lvl  <= lvl - ONE;
                down <= 1'b1;
              end else begin
                lvl <= lvl + ONE;
                if (lvl == MAX - ONE) down <= 1'b1;
              end
            end else begin
              if (lvl == '0) begin
                lvl  <= lvl + ONE;
                down <= 1'b0;
              end else begin
                lvl <= lvl - ONE;
                if (lvl == ONE) down <= 1'b0;
              end
            end
          end
          MODE_SAW: begin
            lvl  <= lvl + ONE;
            down <= 1'b0;
          end
          default: begin
            lvl  <= lvl;
            down <= down;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_breathe_multi.sv
// Testbench for led_breathe_multi with 2 channels, 3-bit intensity and
// a step every 4 cycles. A cycle-level behavioural model tracks level,
// direction, PWM phase and step timing with plain integer arithmetic.
module tb_led_breathe_multi;
  localparam int CH = 2;
  localparam int PB = 3;
  localparam int SD = 4;
  localparam int MAXV = 7;
  localparam logic [1:0] OFF = 2'd0, TRI = 2'd1, SAW = 2'd2, HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [1:0]  mode = TRI;
  logic [1:0]  led;
  logic [5:0]  level;
  logic        step;

  int tests = 0;
  int fails = 0;

  int m_presc;
  int m_lvl [CH];
  int m_acc [CH];
  bit m_down [CH];
  bit m_led [CH];
  bit m_step;

  led_breathe_multi #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .led(led), .level(level), .step(step)
  );

  always #5 clk = ~clk;

  // Reset state of the model: offsets k*8/CH, directions up.
  task automatic model_reset();
    m_presc = 0;
    m_step = 0;
    for (int k = 0; k < CH; k++) begin
      m_lvl[k] = k * (MAXV + 1) / CH;
      m_acc[k] = 0;
      m_down[k] = 0;
      m_led[k] = 0;
    end
  endtask

  // One rising edge of the model using the inputs present at that edge.
  task automatic model_edge();
    bit upd;
    int s;
    upd = en && (mode != OFF) && (m_presc == SD - 1);
    if (mode == OFF) begin
      model_reset();
    end else begin
      for (int k = 0; k < CH; k++) begin
        s = m_acc[k] + m_lvl[k];
        m_led[k] = (s > MAXV);
        m_acc[k] = s % (MAXV + 1);
        if (upd) begin
          if (mode == SAW) begin
            m_lvl[k] = (m_lvl[k] + 1) % (MAXV + 1);
            m_down[k] = 0;
          end else if (mode == TRI) begin
            if (!m_down[k] && m_lvl[k] == MAXV) begin
              m_lvl[k] = MAXV - 1; m_down[k] = 1;
            end else if (m_down[k] && m_lvl[k] == 0) begin
              m_lvl[k] = 1; m_down[k] = 0;
            end else begin
              m_lvl[k] = m_down[k] ? m_lvl[k] - 1 : m_lvl[k] + 1;
              if (m_lvl[k] == MAXV) m_down[k] = 1;
              if (m_lvl[k] == 0) m_down[k] = 0;
            end
          end
        end
      end
      if (en) m_presc = (m_presc + 1) % SD;
      m_step = upd;
    end
  endtask

  function automatic logic [5:0] model_level();
    logic [2:0] a, b;
    a = 3'(m_lvl[0]);
    b = 3'(m_lvl[1]);
    return (mode == OFF) ? 6'd0 : {b, a};
  endfunction

  function automatic logic [1:0] model_led();
    return {m_led[1], m_led[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset with the given mode, en=1, released on a falling edge.
  task automatic start_run(input logic [1:0] m);
    rst = 1'b1;
    mode = m;
    en = 1'b1;
    #1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    start_run(TRI);
    rst = 1'b1;
    #1;
    tests += 3;
    if (led !== 2'b00) begin fails++; $display("[TB] FAIL reset_led got=%b want=00", led); end
    if (step !== 1'b0) begin fails++; $display("[TB] FAIL reset_step got=%b want=0", step); end
    if (level !== 6'b100_000) begin fails++; $display("[TB] FAIL reset_level got=%b want=100000", level); end
  endtask

  task automatic test_tri();
    int exp0 [15] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
    int exp1 [15] = '{5,6,7,6,5,4,3,2,1,0,1,2,3,4,5};
    start_run(TRI);
    for (int n = 1; n <= 60; n++) begin
      tick();
      tests += 3;
      if (step !== (n % SD == 0)) begin fails++; $display("[TB] FAIL tri_step n=%0d got=%b want=%b", n, step, (n % SD == 0)); end
      if (led !== model_led()) begin fails++; $display("[TB] FAIL tri_led n=%0d got=%b want=%b", n, led, model_led()); end
      if (n % SD == 0) begin
        if (level !== {3'(exp1[n/SD-1]), 3'(exp0[n/SD-1])}) begin
          fails++; $display("[TB] FAIL tri_level n=%0d got=%b want ch0=%0d ch1=%0d", n, level, exp0[n/SD-1], exp1[n/SD-1]);
        end
      end else if (level !== model_level()) begin
        fails++; $display("[TB] FAIL tri_level n=%0d got=%b want=%b", n, level, model_level());
      end
    end
  endtask

  task automatic test_saw();
    int j;
    start_run(SAW);
    for (int n = 1; n <= 40; n++) begin
      tick();
      tests += 2;
      if (step !== (n % SD == 0)) begin fails++; $display("[TB] FAIL saw_step n=%0d got=%b want=%b", n, step, (n % SD == 0)); end
      if (led !== model_led()) begin fails++; $display("[TB] FAIL saw_led n=%0d got=%b want=%b", n, led, model_led()); end
      if (n % SD == 0) begin
        j = n / SD;
        tests++;
        if (level !== {3'((j + 4) % 8), 3'(j % 8)}) begin
          fails++; $display("[TB] FAIL saw_level n=%0d got=%b want ch0=%0d ch1=%0d", n, level, j % 8, (j + 4) % 8);
        end
      end
    end
  endtask

  task automatic test_hold();
    int highs = 0;
    start_run(TRI);
    repeat (12) tick();
    tests++;
    if (level[2:0] !== 3'd3) begin fails++; $display("[TB] FAIL hold_start got=%0d want=3", level[2:0]); end
    mode = HOLD;
    for (int n = 13; n <= 40; n++) begin
      tick();
      tests += 3;
      if (level[2:0] !== 3'd3) begin fails++; $display("[TB] FAIL hold_level n=%0d got=%0d want=3", n, level[2:0]); end
      if (step !== (n % SD == 0)) begin fails++; $display("[TB] FAIL hold_step n=%0d got=%b want=%b", n, step, (n % SD == 0)); end
      if (led !== model_led()) begin fails++; $display("[TB] FAIL hold_led n=%0d got=%b want=%b", n, led, model_led()); end
      if (n >= 17 && n <= 24 && led[0]) highs++;
    end
    tests++;
    if (highs != 3) begin fails++; $display("[TB] FAIL hold_duty got=%0d want=3", highs); end
  endtask

  task automatic test_enable();
    int changes = 0;
    logic [1:0] prev;
    start_run(TRI);
    repeat (6) tick();
    en = 1'b0;
    prev = led;
    for (int n = 0; n < 10; n++) begin
      tick();
      tests += 3;
      if (step !== 1'b0) begin fails++; $display("[TB] FAIL en_step n=%0d got=%b want=0", n, step); end
      if (level !== 6'b101_001) begin fails++; $display("[TB] FAIL en_level n=%0d got=%b want=101001", n, level); end
      if (led !== model_led()) begin fails++; $display("[TB] FAIL en_led n=%0d got=%b want=%b", n, led, model_led()); end
      if (led !== prev) changes++;
      prev = led;
    end
    tests++;
    if (changes == 0) begin fails++; $display("[TB] FAIL en_toggle got=0 changes want>0"); end
    en = 1'b1;
    tick();
    tests++;
    if (step !== 1'b0) begin fails++; $display("[TB] FAIL en_resume1 got=%b want=0", step); end
    tick();
    tests += 2;
    if (step !== 1'b1) begin fails++; $display("[TB] FAIL en_resume2 got=%b want=1", step); end
    if (level !== 6'b110_010) begin fails++; $display("[TB] FAIL en_resume_level got=%b want=110010", level); end
  endtask

  task automatic test_off();
    start_run(TRI);
    repeat (10) tick();
    mode = OFF;
    #1;
    tests++;
    if (level !== 6'd0) begin fails++; $display("[TB] FAIL off_mask got=%b want=0", level); end
    for (int n = 0; n < 5; n++) begin
      tick();
      tests += 3;
      if (led !== 2'b00) begin fails++; $display("[TB] FAIL off_led n=%0d got=%b want=00", n, led); end
      if (step !== 1'b0) begin fails++; $display("[TB] FAIL off_step n=%0d got=%b want=0", n, step); end
      if (level !== 6'd0) begin fails++; $display("[TB] FAIL off_level n=%0d got=%b want=0", n, level); end
    end
    mode = TRI;
    #1;
    tests++;
    if (level !== 6'b100_000) begin fails++; $display("[TB] FAIL off_exit_level got=%b want=100000", level); end
    for (int n = 1; n <= 4; n++) begin
      tick();
      tests++;
      if (step !== (n == 4)) begin fails++; $display("[TB] FAIL off_exit_step n=%0d got=%b want=%b", n, step, (n == 4)); end
    end
    tests++;
    if (level !== 6'b101_001) begin fails++; $display("[TB] FAIL off_exit_first got=%b want=101001", level); end
  endtask

  task automatic test_async_reset();
    start_run(TRI);
    repeat (32) tick();
    tests += 2;
    if (level[2:0] !== 3'd6) begin fails++; $display("[TB] FAIL areset_pre got=%0d want=6", level[2:0]); end
    if (step !== 1'b1) begin fails++; $display("[TB] FAIL areset_pre_step got=%b want=1", step); end
    #2;
    rst = 1'b1;
    #1;
    tests += 3;
    if (led !== 2'b00) begin fails++; $display("[TB] FAIL areset_led got=%b want=00", led); end
    if (step !== 1'b0) begin fails++; $display("[TB] FAIL areset_step got=%b want=0", step); end
    if (level !== 6'b100_000) begin fails++; $display("[TB] FAIL areset_level got=%b want=100000", level); end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      tests++;
      if (step !== (n == 4)) begin fails++; $display("[TB] FAIL areset_step_after n=%0d got=%b want=%b", n, step, (n == 4)); end
    end
    tests++;
    if (level !== 6'b101_001) begin fails++; $display("[TB] FAIL areset_first got=%b want=101001", level); end
  endtask

  task automatic test_random();
    start_run(TRI);
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      tick();
      tests += 3;
      if (led !== model_led()) begin fails++; $display("[TB] FAIL rand_led n=%0d got=%b want=%b", n, led, model_led()); end
      if (step !== m_step) begin fails++; $display("[TB] FAIL rand_step n=%0d got=%b want=%b", n, step, m_step); end
      if (level !== model_level()) begin fails++; $display("[TB] FAIL rand_level n=%0d got=%b want=%b", n, level, model_level()); end
    end
  endtask

  initial begin
    test_reset();
    test_tri();
    test_saw();
    test_hold();
    test_enable();
    test_off();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_breathe_multi.md
# led_breathe_multi

Parametrised multi-channel LED "breathing" controller: per channel, a step-rate intensity sequencer (triangle, sawtooth or hold) drives a first-order accumulator PWM output. It generalises the single-LED fixed 3-bit fade to N channels, arbitrary intensity width, selectable waveform mode, enable gating and evenly staggered channel phases. It sits between the board clock and the LED pins; `level` and `step` are exposed for status display and verification.

## Interface
- `CHANNELS`, 4: number of independent LED channels (≥1).
- `PWM_BITS`, 8: intensity / accumulator width; MAX = 2^PWM_BITS − 1.
- `STEP_DIV`, 50000000: clock cycles per intensity step (≥2).

- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  1 = step prescaler runs; 0 = prescaler and levels frozen, PWM keeps running.
- `mode`  in  2  00 OFF, 01 TRI, 10 SAW, 11 HOLD; shared by all channels, sampled every cycle.
- `led`  out  CHANNELS  registered PWM output, bit k = channel k.
- `level`  out  CHANNELS*PWM_BITS  current intensity, channel k at bits [k*PWM_BITS +: PWM_BITS].
- `step`  out  1  registered one-cycle pulse, high in the cycle after each intensity update.

## Operation
- Reset values: `led`=0, `step`=0, prescaler=0, all accumulators=0, all directions=up, level register k = OFS_k = (k·2^PWM_BITS)/CHANNELS truncated to PWM_BITS.
- Prescaler counts 0..STEP_DIV−1 while `en`=1 and mode≠OFF; the edge at STEP_DIV−1 wraps it to 0 and is the update edge. Holds its value while `en`=0.
- Per channel, on update edge:
  - TRI: dir up → level+1; on reaching MAX set dir down. Dir down → level−1; on reaching 0 set dir up. Each of 0 and MAX is held for exactly one step; period 2·MAX steps.
  - SAW: level+1 modulo 2^PWM_BITS (MAX → 0); dir forced up.
  - HOLD: level and dir unchanged (prescaler and `step` still run).
- OFF: prescaler cleared, `step`=0, accumulators cleared, `led`=0, `level` output reads 0; level registers reloaded with OFS_k and dirs set up every cycle, so leaving OFF restarts all channels at their stagger offsets.
- PWM, every cycle in non-OFF modes: {led[k], acc_k} ← acc_k + level_k (PWM_BITS+1-bit sum, carry is LED). Level MAX gives 2^PWM_BITS−1 highs per 2^PWM_BITS cycles; level 0 gives none.
- Mode changes between TRI/SAW/HOLD keep current level and dir; SAW→TRI continues upward.
- `en`=0 concurrently with update condition: no update, no `step`.

## Timing
- From reset release with `en`=1, mode≠OFF: first update on the STEP_DIV-th rising edge; `step` high for the following cycle only; thereafter every STEP_DIV cycles.
- New level visible on `level` in the same cycle `step` is high; PWM accumulation on the update edge uses the old level (one-cycle latency into `led`).
- `led` is registered: carry of the addition at edge n appears after edge n.
- Asserting `rst` mid-operation immediately forces all reset values, independent of `clk`.
- OFF takes effect at the next edge: `led`=0 one cycle after `mode` becomes 00; `level` output masks to 0 combinationally from `mode`.

## Test plan
- CHANNELS=2, PWM_BITS=3, STEP_DIV=4, TRI, `en`=1 from reset -> after reset `level` ch0=0, ch1=4; `step` every 4 cycles; ch0 sequence 1,2,…,7,6,…,0,1 (period 14 steps); ch1 5,6,7,6,5,….
- Same params, SAW -> ch0 6→7→0 wrap on consecutive steps; ch1 runs 4 steps ahead.
- HOLD after ch0 reaches 3 -> `level` ch0 stays 3; over any 8 consecutive settled cycles `led[0]` high exactly 3 times; `step` still pulses every 4 cycles.
- `en`=0 for 10 cycles mid-step (prescaler=2) -> no `step`, levels frozen, `led` keeps toggling; after `en`=1 the next update lands 2 cycles later.
- Mode OFF for 5 cycles, then TRI -> `led`=0 and `level`=0 during OFF; on exit levels 0 and 4, dirs up, first `step` 4 cycles after exit.
- Assert `rst` asynchronously between edges while ch0 is at 6 dir down -> `led`, `step` drop to 0 immediately; levels 0/4 with dirs up; first update STEP_DIV edges after release.
